// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//   Instruction buffer and decode stage between fetch and rename/dispatch.
//   Fetched {pc, inst} pairs enter a DEPTH-entry circular FIFO. The FIFO head
//   is decoded combinationally. The decoded record is captured in an output
//   register that feeds a ready/valid consumer. Total buffering is DEPTH + 1.
//
//   Optional feature: define RV32M_EN to accept M-extension register ops
//   (funct7 = 0000001). Without it those encodings decode as illegal and
//   out_muldiv stays 0.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                synchronous clear of FIFO and output register
//   in_valid/in_ready    fetch handshake; in_inst, in_pc carry the instruction
//   out_valid/out_ready  consumer handshake for the decoded record
//   out_pc, out_inst     PC and raw word of the record
//   out_opcode, out_funct3, out_rd, out_rs1, out_rs2, out_imm
//                        decoded fields (unused register indices read as 0)
//   out_uses_rs1, out_uses_rs2, out_writes_rd, out_muldiv, out_illegal
//                        operand/class flags (all 0 for an illegal record)
//   count                FIFO occupancy, not counting the output register
// -----------------------------------------------------------------------------
module decode_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_imm,
  output logic                       out_uses_rs1,
  output logic                       out_uses_rs2,
  output logic                       out_writes_rd,
  output logic                       out_muldiv,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } rv32i_op_b_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        muldiv;
    logic        illegal;
  } rec_t;

  // FIFO storage (no reset needed: validity is tracked by count/pointers)
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          out_valid_q, out_valid_d;
  rec_t          rec_q, rec_d;

  logic          push, pop;
  rec_t          dec;

  // in_ready depends only on registers and flush; full blocks push even if
  // a pop happens in the same cycle.
  assign in_ready = !flush && (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = !flush && (count_q != '0) && (!out_valid_q || out_ready);

  // ---------------------------------------------------------------------------
  // Combinational decode of the FIFO head
  // ---------------------------------------------------------------------------
  logic [31:0] head_inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        u1, u2, wr, md, ill;

  always_comb begin
    head_inst = fifo_inst_q[rd_ptr_q];
    opc   = head_inst[6:0];
    f3    = head_inst[14:12];
    f7    = head_inst[31:25];
    imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
             head_inst[30:25], head_inst[11:8], 1'b0};
    imm_u = {head_inst[31:12], 12'b0};
    imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
             head_inst[20], head_inst[30:21], 1'b0};

    u1  = 1'b0;
    u2  = 1'b0;
    wr  = 1'b0;
    md  = 1'b0;
    ill = 1'b0;

    dec        = '0;
    dec.pc     = fifo_pc_q[rd_ptr_q];
    dec.inst   = head_inst;
    dec.opcode = opc;
    dec.funct3 = f3;

    case (opc)
      OP_LUI, OP_AUIPC: begin
        dec.imm = imm_u;
        wr      = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j;
        wr      = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i;
        u1      = 1'b1;
        wr      = 1'b1;
        ill     = (f3 != 3'b000);
      end
      OP_BR: begin
        dec.imm = imm_b;
        u1      = 1'b1;
        u2      = 1'b1;
        ill     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_LOAD: begin
        dec.imm = imm_i;
        u1      = 1'b1;
        wr      = 1'b1;
        ill     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.imm = imm_s;
        u1      = 1'b1;
        u2      = 1'b1;
        ill     = (f3 > 3'b010);
      end
      OP_IMM: begin
        dec.imm = imm_i;
        u1      = 1'b1;
        wr      = 1'b1;
        // Shift-immediates reuse the funct7 field as an encoding qualifier
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_REG: begin
        u1 = 1'b1;
        u2 = 1'b1;
        wr = 1'b1;
        case (f7)
          7'b0000000: ill = 1'b0;
          7'b0100000: ill = !((f3 == 3'b000) || (f3 == 3'b101));
          7'b0000001: begin
`ifdef RV32M_EN
            md  = 1'b1;
`else
            ill = 1'b1;
`endif
          end
          default:    ill = 1'b1;
        endcase
      end
      OP_CSR: begin
        dec.imm = imm_i;
        // funct3[2] selects the immediate (uimm) form, which has no rs1
        u1      = !f3[2];
        wr      = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    if (head_inst[1:0] != 2'b11)
      ill = 1'b1;

    wr = wr && (head_inst[11:7] != 5'd0);

    // Illegal records still flow to the ROB but claim no resources
    if (ill) begin
      u1 = 1'b0;
      u2 = 1'b0;
      wr = 1'b0;
      md = 1'b0;
    end

    dec.uses_rs1  = u1;
    dec.uses_rs2  = u2;
    dec.writes_rd = wr;
    dec.muldiv    = md;
    dec.illegal   = ill;
    dec.rd        = wr ? head_inst[11:7]  : 5'd0;
    dec.rs1       = u1 ? head_inst[19:15] : 5'd0;
    dec.rs2       = u2 ? head_inst[24:20] : 5'd0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    rec_d       = rec_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (pop) begin
        out_valid_d = 1'b1;
        rec_d       = dec;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      rec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      rec_q       <= rec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= in_pc;
      fifo_inst_q[wr_ptr_q] <= in_inst;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count         = count_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = rec_q.pc;
  assign out_inst      = rec_q.inst;
  assign out_opcode    = rec_q.opcode;
  assign out_funct3    = rec_q.funct3;
  assign out_rd        = rec_q.rd;
  assign out_rs1       = rec_q.rs1;
  assign out_rs2       = rec_q.rs2;
  assign out_imm       = rec_q.imm;
  assign out_uses_rs1  = rec_q.uses_rs1;
  assign out_uses_rs2  = rec_q.uses_rs2;
  assign out_writes_rd = rec_q.writes_rd;
  assign out_muldiv    = rec_q.muldiv;
  assign out_illegal   = rec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//   Directed bench for decode_queue. Accepted pushes enqueue an expected
//   record; a negedge monitor pops and compares each record the DUT hands
//   over (out_valid && out_ready). Build with RV32M_EN defined to exercise
//   the M-extension expectations.
// -----------------------------------------------------------------------------
module tb_decode_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [6:0]    out_opcode;
  logic [2:0]    out_funct3;
  logic [4:0]    out_rd;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [31:0]   out_imm;
  logic          out_uses_rs1;
  logic          out_uses_rs2;
  logic          out_writes_rd;
  logic          out_muldiv;
  logic          out_illegal;
  logic [CW-1:0] count;

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_rd       (out_rd),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_imm      (out_imm),
    .out_uses_rs1 (out_uses_rs1),
    .out_uses_rs2 (out_uses_rs2),
    .out_writes_rd(out_writes_rd),
    .out_muldiv   (out_muldiv),
    .out_illegal  (out_illegal),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        md;
    logic        ill;
    logic        chk_imm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic u1, input logic u2, input logic wr,
                              input logic md, input logic ill, input logic chk_imm);
    exp_t e;
    e.pc = pc; e.inst = inst; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.u1 = u1; e.u2 = u2; e.wr = wr; e.md = md; e.ill = ill; e.chk_imm = chk_imm;
    return e;
  endfunction

  // addi x1, x0, k
  function automatic exp_t mk_addi(input logic [31:0] pc, input logic [11:0] k);
    return mk(pc, {k, 20'h00093}, 5'd1, 5'd0, 5'd0, {20'd0, k},
              1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  // Illegal record: every flag and index is 0, immediate not checked
  function automatic exp_t mk_ill(input logic [31:0] pc, input logic [31:0] inst);
    return mk(pc, inst, 5'd0, 5'd0, 5'd0, 32'd0,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Output monitor: a record transfers on the edge following this sample
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_output observed pc=%h inst=%h expected none", out_pc, out_inst);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] out pc=%h inst=%h op=%h rd=%0d rs1=%0d rs2=%0d imm=%h u1=%b u2=%b wr=%b md=%b ill=%b",
                 out_pc, out_inst, out_opcode, out_rd, out_rs1, out_rs2, out_imm,
                 out_uses_rs1, out_uses_rs2, out_writes_rd, out_muldiv, out_illegal);
        check("rec_pc",     out_pc,               e.pc);
        check("rec_inst",   out_inst,             e.inst);
        check("rec_opcode", {25'd0, out_opcode},  {25'd0, e.inst[6:0]});
        check("rec_funct3", {29'd0, out_funct3},  {29'd0, e.inst[14:12]});
        check("rec_rd",     {27'd0, out_rd},      {27'd0, e.rd});
        check("rec_rs1",    {27'd0, out_rs1},     {27'd0, e.rs1});
        check("rec_rs2",    {27'd0, out_rs2},     {27'd0, e.rs2});
        if (e.chk_imm)
          check("rec_imm",  out_imm,              e.imm);
        check("rec_u1",     {31'd0, out_uses_rs1},  {31'd0, e.u1});
        check("rec_u2",     {31'd0, out_uses_rs2},  {31'd0, e.u2});
        check("rec_wr",     {31'd0, out_writes_rd}, {31'd0, e.wr});
        check("rec_md",     {31'd0, out_muldiv},    {31'd0, e.md});
        check("rec_ill",    {31'd0, out_illegal},   {31'd0, e.ill});
      end
    end
  end

  // Offer one instruction for one cycle; enqueue its expectation if accepted
  task automatic push(input exp_t e, output bit acc);
    in_valid = 1'b1;
    in_pc    = e.pc;
    in_inst  = e.inst;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    if (acc) sb.push_back(e);
    $display("[TB] push pc=%h inst=%h accepted=%0b", e.pc, e.inst, acc);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   acc_cnt;
    exp_t e;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count",     {28'd0, count},     32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_pc",    out_pc,             32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: addi x1,x0,5 at 0x1000 visible after the second edge
    push(mk_addi(32'h1000, 12'd5), acc);
    check("lat_accept", {31'd0, acc}, 32'd1);
    @(posedge clk); #1;
    check("lat_valid",  {31'd0, out_valid},     32'd1);
    check("lat_opcode", {25'd0, out_opcode},    32'h13);
    check("lat_rd",     {27'd0, out_rd},        32'd1);
    check("lat_rs1",    {27'd0, out_rs1},       32'd0);
    check("lat_imm",    out_imm,                32'd5);
    check("lat_u1",     {31'd0, out_uses_rs1},  32'd1);
    check("lat_wr",     {31'd0, out_writes_rd}, 32'd1);
    check("lat_ill",    {31'd0, out_illegal},   32'd0);
    out_ready = 1'b1;
    drain(20);

    // Fill with out_ready low: DEPTH+1 accepted, then drain across wrap
    out_ready = 1'b0;
    acc_cnt   = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(mk_addi(32'h2000 + 32'(i * 4), 12'(i + 1)), acc);
      if (acc) acc_cnt++;
    end
    check("fill_accepted", 32'(acc_cnt),        32'(DEPTH + 1));
    check("fill_count",    {28'd0, count},      32'(DEPTH));
    check("fill_in_ready", {31'd0, in_ready},   32'd0);
    out_ready = 1'b1;
    drain(60);
    check("drain_count",   {28'd0, count},      32'd0);

    // Back-to-back decode patterns with the consumer always ready
    acc_cnt = 0;
    // beq x1,x2,-4
    push(mk(32'h3000, 32'hFE208EE3, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // sw x2,8(x1)
    push(mk(32'h3004, 32'h0020A423, 5'd0, 5'd1, 5'd2, 32'd8,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // lui x5,0x12345
    push(mk(32'h3008, 32'h123452B7, 5'd5, 5'd0, 5'd0, 32'h12345000,
            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // add x3,x1,x2
    push(mk(32'h300C, 32'h002081B3, 5'd3, 5'd1, 5'd2, 32'd0,
            1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // srai x1,x1,3 (funct7 0100000 legal)
    push(mk(32'h3010, 32'h4030D093, 5'd1, 5'd1, 5'd0, 32'h00000403,
            1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // addi x0,x0,0: rd = 0 so nothing written
    push(mk(32'h3014, 32'h00000013, 5'd0, 5'd0, 5'd0, 32'd0,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
    // Illegal encodings
    push(mk_ill(32'h3018, 32'h00000000), acc); if (acc) acc_cnt++;
    push(mk_ill(32'h301C, 32'h00007083), acc); if (acc) acc_cnt++;
    push(mk_ill(32'h3020, 32'h40001033), acc); if (acc) acc_cnt++;
    push(mk_ill(32'h3024, 32'h02109093), acc); if (acc) acc_cnt++;
    // mul x3,x1,x2
`ifdef RV32M_EN
    push(mk(32'h3028, 32'h022081B3, 5'd3, 5'd1, 5'd2, 32'd0,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), acc); if (acc) acc_cnt++;
`else
    push(mk_ill(32'h3028, 32'h022081B3), acc); if (acc) acc_cnt++;
`endif
    check("stream_accepted", 32'(acc_cnt), 32'd11);
    drain(30);

    // Flush with FIFO half full and an instruction offered in the flush cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH / 2 + 1; i++)
      push(mk_addi(32'h4000 + 32'(i * 4), 12'(16 + i)), acc);
    check("preflush_count", {28'd0, count}, 32'(DEPTH / 2));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h4FFC;
    in_inst  = 32'h7FF00093;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", {28'd0, count},     32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    sb.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push(mk_addi(32'h5000, 12'd42), acc);
    check("postflush_accept", {31'd0, acc}, 32'd1);
    drain(20);

    // Asynchronous reset mid-stream, away from any clock edge
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(mk_addi(32'h6000 + 32'(i * 4), 12'(100 + i)), acc);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",    {31'd0, out_valid}, 32'd0);
    check("arst_count",    {28'd0, count},     32'd0);
    check("arst_out_pc",   out_pc,             32'd0);
    check("arst_out_inst", out_inst,           32'd0);
    check("arst_imm",      out_imm,            32'd0);
    check("arst_in_ready", {31'd0, in_ready},  32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
